// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// Define EX_OVF_EN to add the registered signed-overflow flag (ovf).
interface ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          stall;
    logic          flush;
    logic [1:0]    wb_ctl;
    logic [2:0]    m_ctl;
    logic [3:0]    ex_ctl;
    logic [DW-1:0] npc;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] s_extend;
    logic [RW-1:0] instr_2016;
    logic [RW-1:0] instr_1511;

    logic          out_valid;
    logic [1:0]    wb_ctlout;
    logic [2:0]    m_ctlout;
    logic [DW-1:0] add_result;
    logic          zero;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] rdata2out;
    logic [RW-1:0] muxout;
`ifdef EX_OVF_EN
    logic          ovf;
`endif

    // master drives the ID/EX side and observes EX/MEM
    modport master (
        output in_valid, stall, flush, wb_ctl, m_ctl, ex_ctl, npc, rdata1, rdata2,
               s_extend, instr_2016, instr_1511,
        input  out_valid, wb_ctlout, m_ctlout, add_result, zero, alu_result,
               rdata2out, muxout
`ifdef EX_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, stall, flush, wb_ctl, m_ctl, ex_ctl, npc, rdata1, rdata2,
               s_extend, instr_2016, instr_1511,
        output out_valid, wb_ctlout, m_ctlout, add_result, zero, alu_result,
               rdata2out, muxout
`ifdef EX_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU control decode, operand select, ALU, branch-target add and
// destination select, latched into the EX/MEM register. Optional feature: EX_OVF_EN.
module ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_NONE} alu_op_e;

    typedef struct packed {
        logic          vld;
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [DW-1:0] add_result;
        logic          zero;
        logic [DW-1:0] alu;
        logic [DW-1:0] rdata2;
        logic [RW-1:0] dst;
`ifdef EX_OVF_EN
        logic          ovf;
`endif
    } exmem_t;

    logic          regdst, alusrc;
    logic [1:0]    aluop;
    logic [DW-1:0] op_a, op_b, sum, diff, alu;
    alu_op_e       op;
    logic          keep;
    exmem_t        nxt, q;

    assign regdst = bus.ex_ctl[3];
    assign aluop  = bus.ex_ctl[2:1];
    assign alusrc = bus.ex_ctl[0];
    assign op_a   = bus.rdata1;
    assign op_b   = alusrc ? bus.s_extend : bus.rdata2;
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;

    always_comb begin
        op = OP_NONE;
        unique case (aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (bus.s_extend[5:0])
                    F_ADD:   op = OP_ADD;
                    F_SUB:   op = OP_SUB;
                    F_AND:   op = OP_AND;
                    F_OR:    op = OP_OR;
                    F_SLT:   op = OP_SLT;
                    default: op = OP_NONE;
                endcase
            end
            default: op = OP_NONE;
        endcase
    end

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = sum;
            OP_SUB:  alu = diff;
            OP_AND:  alu = op_a & op_b;
            OP_OR:   alu = op_a | op_b;
            OP_SLT:  alu = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu = '0;
        endcase
    end

`ifdef EX_OVF_EN
    logic ovf_c;
    // signed overflow: result sign disagrees with operands that share (add) or oppose (sub) sign
    always_comb begin
        ovf_c = 1'b0;
        if (op == OP_ADD)
            ovf_c = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1] != op_a[DW-1]);
        else if (op == OP_SUB)
            ovf_c = (op_a[DW-1] != op_b[DW-1]) && (diff[DW-1] != op_a[DW-1]);
    end
`endif

    // a flushed or invalid slot carries no side-effecting control
    assign keep = bus.in_valid && !bus.flush;

    always_comb begin
        nxt            = '0;
        nxt.vld        = keep;
        nxt.wb         = keep ? bus.wb_ctl : 2'b00;
        nxt.m          = keep ? bus.m_ctl  : 3'b000;
        nxt.add_result = bus.npc + (bus.s_extend << 2);
        nxt.zero       = (alu == '0);
        nxt.alu        = alu;
        nxt.rdata2     = bus.rdata2;
        nxt.dst        = regdst ? bus.instr_1511 : bus.instr_2016;
`ifdef EX_OVF_EN
        if (keep && ovf_c) begin
            nxt.ovf   = 1'b1;
            nxt.wb[1] = 1'b0;
            nxt.m[0]  = 1'b0;
        end
`endif
    end

    // flush overrides stall; nxt already holds the bubble in that case
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (bus.flush || !bus.stall)
            q <= nxt;
    end

    assign bus.out_valid  = q.vld;
    assign bus.wb_ctlout  = q.wb;
    assign bus.m_ctlout   = q.m;
    assign bus.add_result = q.add_result;
    assign bus.zero       = q.zero;
    assign bus.alu_result = q.alu;
    assign bus.rdata2out  = q.rdata2;
    assign bus.muxout     = q.dst;
`ifdef EX_OVF_EN
    assign bus.ovf        = q.ovf;
`endif
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that sits directly downstream of the ID/EX pipeline register. Consumes that register's outputs, performs ALU control decode, operand select, ALU operation, branch-target add and destination-register select.
- Latches all results into an internal EX/MEM pipeline register that feeds the memory stage.
- Supports stall (hold) and flush (bubble insertion) with a valid bit. Latency is 1 clock.

Parameters:
- DW, 32, datapath width (npc, operands, results)
- RW, 5, register-index width

Ports:
- clk  in  1  clock, all flops on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- in_valid  in  1  ID/EX slot holds a real instruction
- stall  in  1  hold EX/MEM contents
- flush  in  1  replace the next EX/MEM contents with a bubble
- wb_ctl  in  2  {regwrite, memtoreg}
- m_ctl  in  3  {branch, memread, memwrite}
- ex_ctl  in  4  {regdst, aluop[1:0], alusrc}
- npc  in  DW  PC+4 of the instruction
- rdata1  in  DW  rs value
- rdata2  in  DW  rt value
- s_extend  in  DW  sign-extended immediate; [5:0] is funct
- instr_2016  in  RW  rt index
- instr_1511  in  RW  rd index
- out_valid  out  1  EX/MEM slot valid
- wb_ctlout  out  2  registered wb_ctl
- m_ctlout  out  3  registered m_ctl
- add_result  out  DW  registered branch target
- zero  out  1  registered (alu_result == 0)
- alu_result  out  DW  registered ALU output
- rdata2out  out  DW  registered rdata2, used as store data
- muxout  out  RW  registered destination index

Behaviour:
- Reset (rst=0, asynchronous): all outputs go to 0 immediately and stay 0 while rst=0.
- Combinational datapath:
  - B operand = alusrc ? s_extend : rdata2.
  - add_result = npc + (s_extend << 2), truncated to DW, wrap-around ignored.
  - muxout = regdst ? instr_1511 : instr_2016.
- ALU control:
  - aluop 00: add.
  - aluop 01: sub.
  - aluop 10: decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1 or 0).
  - aluop 11, or any unlisted funct: alu_result = 0.
  - Add and sub wrap modulo 2^DW.
- Register update, rising edge, in priority order:
  1. flush=1: out_valid, wb_ctlout, m_ctlout cleared to 0. Data fields load normally and are don't-care. Flush wins over stall.
  2. stall=1: every register holds its value.
  3. Otherwise: every register loads. out_valid <= in_valid. If in_valid=0, wb_ctlout and m_ctlout load 0, so a bubble never writes a register or memory.
- Latency: an operand pair presented at edge N is visible on the outputs after edge N+1.
- Releasing rst asynchronously mid-stream: the first edge after release loads normally. No state persists across reset.

Optional Feature:
- Macro: EX_OVF_EN.
- When defined:
  - Extra output port ovf, 1 bit, registered, reset 0.
  - ovf is set when a signed add or sub (aluop 00/01, funct add/sub) overflows and the slot is valid and not flushed.
  - On overflow, wb_ctlout[1] (regwrite) and m_ctlout[0] (memwrite) are forced 0 in the same load.
  - ovf follows the same stall and flush rules as the other outputs.
- When undefined: no ovf port, and results wrap silently.

Test Plan:
- Async reset: drive nonzero inputs, pull rst=0 between clock edges → all outputs 0 without waiting for an edge. Release, then one edge → outputs load.
- R-type add: ex_ctl=4'b1100, rdata1=15, rdata2=20, funct=100000, instr_1511=3, in_valid=1 → next edge alu_result=35, zero=0, muxout=3, out_valid=1.
- Branch sub: ex_ctl=4'b0010, rdata1=rdata2=10, npc=5, s_extend=4, m_ctl=3'b100 → alu_result=0, zero=1, add_result=21, muxout=instr_2016.
- I-type slt: ex_ctl=4'b0101 (aluop 10) with funct=101010, rdata1=-1, s_extend=0x0000002A → alu_result=1. Same setup with alusrc=0 and rdata2=-5 → alu_result=0.
- Stall/flush: load one instruction, assert stall for 2 cycles with new inputs → outputs unchanged. Assert stall and flush together → out_valid=0, wb_ctlout=0, m_ctlout=0.
- Bubble, plus EX_OVF_EN: in_valid=0 with wb_ctl=2'b11 → wb_ctlout=0. With EX_OVF_EN defined, add 0x7FFFFFFF + 1 with wb_ctl=2'b10 → ovf=1, wb_ctlout=0, alu_result=0x80000000.
